// File: rtl/exec_unit.sv
// exec_unit: execute stage. Single-cycle ALU ops plus an iterative
// shift-add multiplier that back-pressures decode through stall.
module exec_unit #(
   parameter int DSIZE = 16,
   parameter int ISIZE = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [3:0]       op,
   input  logic [DSIZE-1:0] rdata1,
   input  logic [DSIZE-1:0] rdata2,
   input  logic [ISIZE-1:0] PC_in,
   output logic [DSIZE-1:0] aluout,
   output logic [ISIZE-1:0] PC_out,
   output logic             valid_out,
   output logic             zero,
   output logic             stall
);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOR = 4'h5;
   localparam logic [3:0] OP_SLL = 4'h6;
   localparam logic [3:0] OP_SRL = 4'h7;
   localparam logic [3:0] OP_SRA = 4'h8;
   localparam logic [3:0] OP_MUL = 4'h9;
   localparam logic [3:0] OP_SLT = 4'hA;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           state, state_nx;
   logic             busy, busy_nx;
   logic [SHW-1:0]   count, count_nx;
   logic [DSIZE-1:0] mcand, mcand_nx;
   logic [DSIZE-1:0] mplier, mplier_nx;
   logic [DSIZE-1:0] acc, acc_nx;
   logic [ISIZE-1:0] pc_hold, pc_hold_nx;
   logic [DSIZE-1:0] aluout_nx;
   logic [ISIZE-1:0] pc_out_nx;
   logic             zero_nx, valid_nx;
   logic [DSIZE-1:0] alu_res;
   logic [DSIZE-1:0] acc_sum;
   logic [SHW-1:0]   shamt;

   assign stall = busy;
   assign shamt = rdata2[SHW-1:0];

   // Single-cycle ALU result for the incoming instruction
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD: alu_res = rdata1 + rdata2;
         OP_SUB: alu_res = rdata1 - rdata2;
         OP_AND: alu_res = rdata1 & rdata2;
         OP_OR:  alu_res = rdata1 | rdata2;
         OP_XOR: alu_res = rdata1 ^ rdata2;
         OP_NOR: alu_res = ~(rdata1 | rdata2);
         OP_SLL: alu_res = rdata1 << shamt;
         OP_SRL: alu_res = rdata1 >> shamt;
         OP_SRA: alu_res = DSIZE'($signed(rdata1) >>> shamt);
         OP_SLT: alu_res = {{(DSIZE-1){1'b0}}, $signed(rdata1) < $signed(rdata2)};
         default: alu_res = '0;
      endcase
   end

   // Accumulator plus the current partial product
   always_comb begin
      acc_sum = mplier[0] ? (acc + mcand) : acc;
   end

   // Next-state and next-output logic for the IDLE/MUL sequencer
   always_comb begin
      state_nx   = state;
      busy_nx    = busy;
      count_nx   = count;
      mcand_nx   = mcand;
      mplier_nx  = mplier;
      acc_nx     = acc;
      pc_hold_nx = pc_hold;
      aluout_nx  = aluout;
      pc_out_nx  = PC_out;
      zero_nx    = zero;
      valid_nx   = 1'b0;
      case (state)
         S_IDLE: begin
            if (valid_in && !busy) begin
               if (op == OP_MUL) begin
                  mcand_nx   = rdata1;
                  mplier_nx  = rdata2;
                  pc_hold_nx = PC_in;
                  acc_nx     = '0;
                  count_nx   = '0;
                  busy_nx    = 1'b1;
                  state_nx   = S_MUL;
               end else begin
                  aluout_nx = alu_res;
                  pc_out_nx = PC_in;
                  zero_nx   = (alu_res == '0);
                  valid_nx  = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_nx    = acc_sum;
            mcand_nx  = mcand << 1;
            mplier_nx = mplier >> 1;
            count_nx  = count + SHW'(1);
            // The last partial product is folded in on the same edge that
            // publishes the result, so completion lands DSIZE edges after accept.
            if (count == SHW'(DSIZE - 1)) begin
               aluout_nx = acc_sum;
               pc_out_nx = pc_hold;
               zero_nx   = (acc_sum == '0);
               valid_nx  = 1'b1;
               busy_nx   = 1'b0;
               count_nx  = '0;
               state_nx  = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         count     <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         pc_hold   <= '0;
         aluout    <= '0;
         PC_out    <= '0;
         zero      <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_nx;
         busy      <= busy_nx;
         count     <= count_nx;
         mcand     <= mcand_nx;
         mplier    <= mplier_nx;
         acc       <= acc_nx;
         pc_hold   <= pc_hold_nx;
         aluout    <= aluout_nx;
         PC_out    <= pc_out_nx;
         zero      <= zero_nx;
         valid_out <= valid_nx;
      end
   end

endmodule
